// File: rtl/pc_branch_unit_if.sv
// Signal bundle between decode/fetch and the PC/branch stage.
// The taken_count signal exists only when BRANCH_COUNT_EN is defined.
interface pc_branch_unit_if #(
    parameter int unsigned PC_W = 32
);
    logic            stall;
    logic            br_valid;
    logic [2:0]      br_type;
    logic [PC_W-1:0] br_pc;
    logic [31:0]     offset;
    logic [31:0]     reg_target;
    logic [31:0]     rs_val;
    logic            carry;
    logic [PC_W-1:0] pc;
    logic            flush;
    logic            link_we;
    logic [31:0]     link_data;
    logic            redirect_pending;
`ifdef BRANCH_COUNT_EN
    logic [15:0]     taken_count;

    modport master (
        output stall, br_valid, br_type, br_pc, offset, reg_target, rs_val, carry,
        input  pc, flush, link_we, link_data, redirect_pending, taken_count
    );
    modport slave (
        input  stall, br_valid, br_type, br_pc, offset, reg_target, rs_val, carry,
        output pc, flush, link_we, link_data, redirect_pending, taken_count
    );
`else
    modport master (
        output stall, br_valid, br_type, br_pc, offset, reg_target, rs_val, carry,
        input  pc, flush, link_we, link_data, redirect_pending
    );
    modport slave (
        input  stall, br_valid, br_type, br_pc, offset, reg_target, rs_val, carry,
        output pc, flush, link_we, link_data, redirect_pending
    );
`endif
endinterface

// File: rtl/pc_branch_unit.sv
// Program counter and branch resolution: evaluates the branch condition, redirects fetch and
// emits one-cycle flush/link pulses. Define BRANCH_COUNT_EN to add a saturating taken_count.
module pc_branch_unit #(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     INC      = 1
) (
    input logic             clk,
    input logic             rst,
    pc_branch_unit_if.slave bus
);

    typedef enum logic [2:0] {
        BrB, BrReg, BrLtz, BrZ, BrNz, BrL, BrCy, BrNcy
    } br_type_e;

    typedef enum logic [0:0] {StRun, StPending} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;
    logic            link_we_q, link_we_d;
    logic [31:0]     link_data_q, link_data_d;
    logic [PC_W-1:0] tgt_q, tgt_d;
    logic            pend_bl_q, pend_bl_d;
    logic [31:0]     pend_link_q, pend_link_d;

    logic            taken;
    logic            accept;
    logic            is_bl;
    logic [PC_W-1:0] target;
    logic [31:0]     link_val;

    always_comb begin
        taken = 1'b0;
        unique case (br_type_e'(bus.br_type))
            BrB, BrReg, BrL: taken = 1'b1;
            BrLtz:           taken = bus.rs_val[31];
            BrZ:             taken = (bus.rs_val == '0);
            BrNz:            taken = (bus.rs_val != '0);
            BrCy:            taken = bus.carry;
            BrNcy:           taken = ~bus.carry;
            default:         taken = 1'b0;
        endcase
    end

    // The instruction in decode during a flush cycle is wrong-path and must not redirect again.
    assign accept   = bus.br_valid && !flush_q && taken;
    assign is_bl    = (br_type_e'(bus.br_type) == BrL);
    assign target   = (br_type_e'(bus.br_type) == BrReg) ? bus.reg_target[PC_W-1:0]
                                                         : bus.br_pc + bus.offset[PC_W-1:0];
    assign link_val = 32'(bus.br_pc + PC_W'(INC));

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_d     = 1'b0;
        link_we_d   = 1'b0;
        link_data_d = link_data_q;
        tgt_d       = tgt_q;
        pend_bl_d   = pend_bl_q;
        pend_link_d = pend_link_q;
        unique case (state_q)
            StRun: begin
                if (!bus.stall) begin
                    if (accept) begin
                        pc_d    = target;
                        flush_d = 1'b1;
                        if (is_bl) begin
                            link_we_d   = 1'b1;
                            link_data_d = link_val;
                        end
                    end else begin
                        pc_d = pc_q + PC_W'(INC);
                    end
                end else if (accept) begin
                    state_d     = StPending;
                    tgt_d       = target;
                    pend_bl_d   = is_bl;
                    pend_link_d = link_val;
                end
            end
            StPending: begin
                if (!bus.stall) begin
                    state_d = StRun;
                    pc_d    = tgt_q;
                    flush_d = 1'b1;
                    if (pend_bl_q) begin
                        link_we_d   = 1'b1;
                        link_data_d = pend_link_q;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            flush_q     <= 1'b0;
            link_we_q   <= 1'b0;
            link_data_q <= '0;
            tgt_q       <= '0;
            pend_bl_q   <= 1'b0;
            pend_link_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_q     <= flush_d;
            link_we_q   <= link_we_d;
            link_data_q <= link_data_d;
            tgt_q       <= tgt_d;
            pend_bl_q   <= pend_bl_d;
            pend_link_q <= pend_link_d;
        end
    end

    assign bus.pc               = pc_q;
    assign bus.flush            = flush_q;
    assign bus.link_we          = link_we_q;
    assign bus.link_data        = link_data_q;
    assign bus.redirect_pending = (state_q == StPending);

`ifdef BRANCH_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (flush_d && count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign bus.taken_count = count_q;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_pc_branch_unit;
    localparam int unsigned PC_W     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;

    pc_branch_unit_if #(.PC_W(PC_W)) bus ();

    pc_branch_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC), .INC(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_link_data, m_tgt, m_plink;
    logic        m_flush, m_link_we, m_pend, m_pbl;
    int          m_count;

    function automatic bit m_taken(input logic [2:0] t, input logic [31:0] rs, input logic c);
        case (t)
            3'd2:    return $signed(rs) < 0;
            3'd3:    return rs == 32'd0;
            3'd4:    return rs != 32'd0;
            3'd6:    return c == 1'b1;
            3'd7:    return c == 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Advance the model using the inputs presented this cycle, then clock the DUT.
    task automatic tick();
        logic [31:0] tgt;
        bit          tk;
        bit          was_flush;
        if (rst) begin
            m_pc = RESET_PC; m_flush = 0; m_link_we = 0; m_link_data = 0; m_pend = 0;
            m_count = 0;
        end else begin
            was_flush = m_flush;
            m_flush = 0;
            m_link_we = 0;
            if (m_pend) begin
                if (!bus.stall) begin
                    m_pc = m_tgt; m_flush = 1; m_pend = 0;
                    if (m_pbl) begin m_link_we = 1; m_link_data = m_plink; end
                end
            end else begin
                tk  = bus.br_valid && !was_flush && m_taken(bus.br_type, bus.rs_val, bus.carry);
                tgt = (bus.br_type == 3'd1) ? bus.reg_target : bus.br_pc + bus.offset;
                if (tk && bus.stall) begin
                    m_pend = 1; m_tgt = tgt; m_pbl = (bus.br_type == 3'd5);
                    m_plink = bus.br_pc + 32'd1;
                end else if (tk) begin
                    m_pc = tgt; m_flush = 1;
                    if (bus.br_type == 3'd5) begin m_link_we = 1; m_link_data = bus.br_pc + 1; end
                end else if (!bus.stall) begin
                    m_pc = m_pc + 32'd1;
                end
            end
            if (m_flush && m_count < 65535) m_count++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic [2:0] t, input logic [31:0] bpc, input logic [31:0] off);
        bus.br_valid = 1'b1;
        bus.br_type  = t;
        bus.br_pc    = bpc;
        bus.offset   = off;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++; if (bus.pc !== RESET_PC) begin errors++;
            $display("FAIL reset_pc: got %h want %h", bus.pc, RESET_PC); end
        checks++; if (bus.flush !== 1'b0 || bus.link_we !== 1'b0) begin errors++;
            $display("FAIL reset_pulses: flush=%b link_we=%b want 0 0", bus.flush, bus.link_we); end
        checks++; if (bus.link_data !== 32'd0) begin errors++;
            $display("FAIL reset_link_data: got %h want 0", bus.link_data); end
        checks++; if (bus.redirect_pending !== 1'b0) begin errors++;
            $display("FAIL reset_pending: got %b want 0", bus.redirect_pending); end
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++; if (bus.pc !== 32'(i) || bus.flush !== 1'b0) begin errors++;
                $display("FAIL seq_pc[%0d]: pc=%h flush=%b want %h 0", i, bus.pc, bus.flush, i); end
        end
    endtask

    task automatic test_branch_b();
        set_br(3'd0, 32'h10, 32'hFFFF_FFF8);
        tick();
        bus.br_valid = 1'b0;
        checks++; if (bus.pc !== 32'h08 || bus.flush !== 1'b1) begin errors++;
            $display("FAIL b_taken: pc=%h flush=%b want 08 1", bus.pc, bus.flush); end
        tick();
        checks++; if (bus.pc !== 32'h09 || bus.flush !== 1'b0) begin errors++;
            $display("FAIL b_after: pc=%h flush=%b want 09 0", bus.pc, bus.flush); end
    endtask

    task automatic test_bz();
        set_br(3'd0, 32'h0, 32'h1F);
        tick();
        bus.br_valid = 1'b0;
        tick();
        checks++; if (bus.pc !== 32'h20) begin errors++;
            $display("FAIL bz_setup: pc=%h want 20", bus.pc); end
        set_br(3'd3, 32'h20, 32'h4);
        bus.rs_val = 32'd5;
        tick();
        checks++; if (bus.pc !== 32'h21 || bus.flush !== 1'b0) begin errors++;
            $display("FAIL bz_not_taken: pc=%h flush=%b want 21 0", bus.pc, bus.flush); end
        bus.rs_val = 32'd0;
        tick();
        bus.br_valid = 1'b0;
        checks++; if (bus.pc !== 32'h24 || bus.flush !== 1'b1) begin errors++;
            $display("FAIL bz_taken: pc=%h flush=%b want 24 1", bus.pc, bus.flush); end
        tick();
    endtask

    task automatic test_bl_stall();
        logic [31:0] held;
        int          lwe_pulses;
        int          flush_pulses;
        held = bus.pc;
        set_br(3'd5, 32'h30, 32'h100);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.redirect_pending !== 1'b1 || bus.pc !== held) begin errors++;
                $display("FAIL bl_pending[%0d]: pending=%b pc=%h want 1 %h", i,
                         bus.redirect_pending, bus.pc, held); end
            checks++; if (bus.flush !== 1'b0 || bus.link_we !== 1'b0) begin errors++;
                $display("FAIL bl_quiet[%0d]: flush=%b link_we=%b want 0 0", i, bus.flush,
                         bus.link_we); end
        end
        bus.stall = 1'b0;
        tick();
        bus.br_valid = 1'b0;
        checks++; if (bus.pc !== 32'h130 || bus.flush !== 1'b1 || bus.redirect_pending !== 1'b0)
            begin errors++;
            $display("FAIL bl_release: pc=%h flush=%b pending=%b want 130 1 0", bus.pc,
                     bus.flush, bus.redirect_pending); end
        checks++; if (bus.link_we !== 1'b1 || bus.link_data !== 32'h31) begin errors++;
            $display("FAIL bl_link: link_we=%b link_data=%h want 1 31", bus.link_we,
                     bus.link_data); end
        lwe_pulses = 0;
        flush_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            lwe_pulses += int'(bus.link_we);
            flush_pulses += int'(bus.flush);
        end
        checks++; if (lwe_pulses != 0 || flush_pulses != 0 || bus.pc !== 32'h134) begin errors++;
            $display("FAIL bl_single_pulse: extra link_we=%0d flush=%0d pc=%h want 0 0 134",
                     lwe_pulses, flush_pulses, bus.pc); end
    endtask

    task automatic test_back_to_back();
        set_br(3'd0, 32'h40, 32'h10);
        tick();
        set_br(3'd0, 32'h60, 32'h10);
        tick();
        bus.br_valid = 1'b0;
        checks++; if (bus.pc !== 32'h51 || bus.flush !== 1'b0) begin errors++;
            $display("FAIL b2b_ignored: pc=%h flush=%b want 51 0", bus.pc, bus.flush); end
    endtask

    task automatic test_wrap();
        set_br(3'd0, 32'hFFFF_FFF0, 32'h20);
        tick();
        bus.br_valid = 1'b0;
        checks++; if (bus.pc !== 32'h10) begin errors++;
            $display("FAIL target_wrap: pc=%h want 10", bus.pc); end
        tick();
        set_br(3'd0, 32'h0, 32'hFFFF_FFFF);
        tick();
        bus.br_valid = 1'b0;
        tick();
        checks++; if (bus.pc !== 32'h0) begin errors++;
            $display("FAIL pc_wrap: pc=%h want 0", bus.pc); end
    endtask

    task automatic test_reset_priority();
        set_br(3'd1, 32'h50, 32'h0);
        bus.reg_target = 32'hDEAD_0000;
        bus.stall = 1'b1;
        rst = 1'b1;
        tick();
        checks++; if (bus.pc !== RESET_PC || bus.flush !== 1'b0 || bus.link_we !== 1'b0 ||
                      bus.redirect_pending !== 1'b0) begin errors++;
            $display("FAIL rst_priority: pc=%h flush=%b link_we=%b pending=%b want %h 0 0 0",
                     bus.pc, bus.flush, bus.link_we, bus.redirect_pending, RESET_PC); end
        rst = 1'b0;
        bus.stall = 1'b0;
        bus.br_valid = 1'b0;
        tick();
        checks++; if (bus.pc !== RESET_PC + 32'd1 || bus.flush !== 1'b0) begin errors++;
            $display("FAIL rst_release: pc=%h flush=%b want %h 0", bus.pc, bus.flush,
                     RESET_PC + 32'd1); end
    endtask

`ifdef BRANCH_COUNT_EN
    task automatic test_count();
        logic [2:0]  types [5] = '{3'd0, 3'd3, 3'd4, 3'd6, 3'd7};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.rs_val = 32'd0;
        bus.carry = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_br(types[i], 32'h100 * i, 32'h8);
            tick();
            bus.br_valid = 1'b0;
            tick();
        end
        checks++; if (bus.taken_count !== 16'd3) begin errors++;
            $display("FAIL count_three: got %0d want 3", bus.taken_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.taken_count !== 16'd0) begin errors++;
            $display("FAIL count_reset: got %0d want 0", bus.taken_count); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] v;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 59) == 0);
            bus.stall    = ($urandom_range(0, 2) == 0);
            bus.br_valid = $urandom_range(0, 1) == 1;
            bus.br_type  = 3'($urandom_range(0, 7));
            bus.br_pc    = $urandom();
            bus.offset   = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($signed($urandom_range(0, 64)) - 32);
            bus.reg_target = $urandom();
            v = $urandom();
            case ($urandom_range(0, 2))
                0:       bus.rs_val = 32'd0;
                1:       bus.rs_val = v | 32'h8000_0000;
                default: bus.rs_val = v & 32'h7FFF_FFFF;
            endcase
            bus.carry = $urandom_range(0, 1) == 1;
            tick();
            checks++; if (bus.pc !== m_pc) begin errors++;
                $display("FAIL rnd_pc[%0d]: got %h want %h", i, bus.pc, m_pc); end
            checks++; if (bus.flush !== m_flush || bus.link_we !== m_link_we) begin errors++;
                $display("FAIL rnd_pulses[%0d]: flush=%b link_we=%b want %b %b", i, bus.flush,
                         bus.link_we, m_flush, m_link_we); end
            checks++; if (bus.redirect_pending !== m_pend) begin errors++;
                $display("FAIL rnd_pending[%0d]: got %b want %b", i, bus.redirect_pending,
                         m_pend); end
            if (m_link_we) begin
                checks++; if (bus.link_data !== m_link_data) begin errors++;
                    $display("FAIL rnd_link_data[%0d]: got %h want %h", i, bus.link_data,
                             m_link_data); end
            end
`ifdef BRANCH_COUNT_EN
            checks++; if (bus.taken_count !== 16'(m_count)) begin errors++;
                $display("FAIL rnd_count[%0d]: got %0d want %0d", i, bus.taken_count, m_count); end
`endif
        end
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.stall      = 1'b0;
        bus.br_valid   = 1'b0;
        bus.br_type    = 3'd0;
        bus.br_pc      = '0;
        bus.offset     = '0;
        bus.reg_target = '0;
        bus.rs_val     = '0;
        bus.carry      = 1'b0;
        test_reset();
        test_branch_b();
        test_bz();
        test_bl_stall();
        test_back_to_back();
        test_wrap();
        test_reset_priority();
`ifdef BRANCH_COUNT_EN
        test_count();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter and branch-resolution stage that sits directly downstream of the 24→32 label sign-extender.
- Consumes the sign-extended 32-bit label offset and the decoded branch type, evaluates the branch condition, and computes the target.
- Drives the instruction-memory fetch address.
- Produces a one-cycle flush pulse to the fetch/decode register and a link write for call-type branches.

Parameters:
- PC_W, 32, program-counter width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INC, 1, sequential PC increment (instruction memory is word-addressed).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  hazard hold; PC and pending state are frozen while high.
- br_valid  in  1  branch instruction present in decode this cycle.
- br_type  in  3  0=b, 1=br (register), 2=bltz, 3=bz, 4=bnz, 5=bl (call), 6=bcy, 7=bncy.
- br_pc  in  PC_W  address of the branch instruction.
- offset  in  32  sign-extended label offset.
- reg_target  in  32  register value; used as the absolute target for br.
- rs_val  in  32  operand tested by bltz/bz/bnz.
- carry  in  1  ALU carry flag for bcy/bncy.
- pc  out  PC_W  current fetch address.
- flush  out  1  one-cycle pulse; invalidates the wrong-path instruction.
- link_we  out  1  one-cycle write enable for the link register (ra).
- link_data  out  32  return address, br_pc + INC.
- redirect_pending  out  1  high while a taken target waits for a stall to release.

Behaviour:
- Reset (rst high at a rising edge) forces: pc=RESET_PC, flush=0, link_we=0, link_data=0, redirect_pending=0, state=RUN. Reset has priority over every other input, including a branch or stall in the same cycle.
- Condition evaluation (combinational, only when br_valid=1):
  - b, br and bl are always taken.
  - bltz is taken when rs_val[31]=1.
  - bz is taken when rs_val==0; bnz when rs_val!=0.
  - bcy is taken when carry=1; bncy when carry=0.
- Target:
  - br uses reg_target[PC_W-1:0].
  - All other types use br_pc + offset, truncated modulo 2^PC_W. Wrap-around is silent, with no overflow flag.
- State RUN:
  - stall=0, no taken branch: pc <= pc + INC (wraps modulo 2^PC_W).
  - stall=0, taken branch: pc <= target and flush=1 for the next cycle only. Latency is 1 cycle, so the target appears on pc the cycle after br_valid.
  - stall=1, taken branch: latch the target into an internal register, go to PENDING, set redirect_pending=1; pc holds.
  - stall=1, no taken branch: pc holds.
  - Not-taken branch: behaves exactly as sequential; flush=0.
- State PENDING:
  - While stall=1: pc holds and the latched target is kept.
  - First cycle with stall=0: pc <= latched target, flush=1, redirect_pending=0, return to RUN.
  - br_valid is ignored in PENDING, because decode holds the same instruction.
- Link:
  - bl taken with stall=0 in RUN: link_we=1 and link_data=br_pc+INC in the cycle after acceptance.
  - bl accepted under stall: link_data and link_we are produced on the PENDING→RUN redirect instead.
  - link_we never pulses twice for one bl.
- flush and link_we are registered and are 1 for exactly one cycle per redirect. Outside redirects they are 0.
- Back-to-back: a new br_valid in the cycle flush=1 is ignored by this block, because the wrong-path instruction is being squashed. Sequential increment continues from the new pc.

Optional Feature:
- Macro BRANCH_COUNT_EN.
- When defined:
  - Adds output taken_count [15:0].
  - taken_count increments once per redirect (the cycle flush is asserted) and saturates at 16'hFFFF.
  - It clears to 0 on rst.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset then release with stall=0 for 5 cycles → pc sequence 0,1,2,3,4,5; flush=0 throughout.
- br_valid=1, type b, br_pc=0x10, offset=0xFFFFFFF8 → next cycle pc=0x08, flush=1 for one cycle, then pc=0x09.
- type bz, rs_val=5, br_pc=0x20 → not taken, pc=0x21, flush=0. Repeat with rs_val=0, offset=4 → pc=0x24, flush=1.
- type bl, br_pc=0x30, offset=0x100, stall=1 for 3 cycles → redirect_pending=1 with pc frozen. On stall release: pc=0x130, flush=1, link_we=1, link_data=0x31, each asserted once.
- type br, reg_target=0xDEAD0000 with rst asserted in the same cycle → pc=RESET_PC, no flush, no link.
- BRANCH_COUNT_EN build, 3 taken plus 2 not-taken branches → taken_count=3. Mid-run reset → 0.
